// File: rtl/fir_mac_pkg.sv
// Shared types, default widths and configuration checks for the time-multiplexed
// FIR multiply-accumulate sequencer.
package fir_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } fir_state_e;

  localparam int DEF_A_DATA_WIDTH = 25;
  localparam int DEF_B_DATA_WIDTH = 18;
  localparam int DEF_P_DATA_WIDTH = 48;
  localparam int DEF_NTAPS        = 16;

  // One cycle per tap plus the DRAIN cycle that captures the slice output.
  localparam int FIR_LATENCY = DEF_NTAPS + 1;

  function automatic int firLatency(input int ntaps);
    return ntaps + 1;
  endfunction

  // The accumulator must hold NTAPS full-scale products without wrapping.
  function automatic bit ntapsValid(input int ntaps, input int aWidth,
                                    input int bWidth, input int pWidth);
    return (ntaps >= 2) && (ntaps <= 32) && ((ntaps & (ntaps - 1)) == 0) &&
           (aWidth + bWidth + $clog2(ntaps) <= pWidth);
  endfunction

endpackage

// File: rtl/fir_mac_ctrl_if.sv
// Bundles the sample stream, coefficient write port, DSP slice drive and result
// stream of the FIR sequencer; master is the sequencer, slave its environment.
interface fir_mac_ctrl_if
  import fir_mac_pkg::*;
#(
  parameter int A_DATA_WIDTH = DEF_A_DATA_WIDTH,
  parameter int B_DATA_WIDTH = DEF_B_DATA_WIDTH,
  parameter int P_DATA_WIDTH = DEF_P_DATA_WIDTH,
  parameter int NTAPS        = DEF_NTAPS
) ();

  localparam int ADDR_WIDTH = $clog2(NTAPS);

  logic [A_DATA_WIDTH-1:0] s_data_i;
  logic                    s_valid_i;
  logic                    s_ready_o;

  logic                    coef_we_i;
  logic [ADDR_WIDTH-1:0]   coef_addr_i;
  logic [B_DATA_WIDTH-1:0] coef_data_i;

  logic                    dsp_acc_o;
  logic [A_DATA_WIDTH-1:0] dsp_a_o;
  logic [B_DATA_WIDTH-1:0] dsp_b_o;
  logic [P_DATA_WIDTH-1:0] dsp_p_i;

  logic [P_DATA_WIDTH-1:0] m_data_o;
  logic                    m_valid_o;
  logic                    m_ready_i;

  modport master (
    input  s_data_i, s_valid_i,
    output s_ready_o,
    input  coef_we_i, coef_addr_i, coef_data_i,
    output dsp_acc_o, dsp_a_o, dsp_b_o,
    input  dsp_p_i,
    output m_data_o, m_valid_o,
    input  m_ready_i
  );

  modport slave (
    output s_data_i, s_valid_i,
    input  s_ready_o,
    output coef_we_i, coef_addr_i, coef_data_i,
    input  dsp_acc_o, dsp_a_o, dsp_b_o,
    output dsp_p_i,
    input  m_data_o, m_valid_o,
    output m_ready_i
  );

endinterface

// File: rtl/fir_mac_hist.sv
// Circular sample history: each write lands at the write pointer and becomes the
// newest sample; the read port returns the sample i_tap positions older than newest.
module fir_mac_hist
  import fir_mac_pkg::*;
#(
  parameter int A_DATA_WIDTH = DEF_A_DATA_WIDTH,
  parameter int NTAPS        = DEF_NTAPS
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          i_we,
  input  logic [A_DATA_WIDTH-1:0]       i_wdata,
  input  logic [$clog2(NTAPS)-1:0]      i_tap,
  output logic [A_DATA_WIDTH-1:0]       o_rdata
);

  localparam int ADDR_WIDTH = $clog2(NTAPS);

  logic [A_DATA_WIDTH-1:0] r_hist [NTAPS];
  logic [ADDR_WIDTH-1:0]   r_wrPtr;
  logic [ADDR_WIDTH-1:0]   r_newest;
  logic [ADDR_WIDTH-1:0]   w_rdIdx;

  // Pointer arithmetic wraps naturally because NTAPS is a power of two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_hist[i] <= '0;
      end
      r_wrPtr  <= '0;
      r_newest <= '0;
    end else if (i_we) begin
      r_hist[r_wrPtr] <= i_wdata;
      r_newest        <= r_wrPtr;
      r_wrPtr         <= r_wrPtr + 1'b1;
    end
  end

  assign w_rdIdx = r_newest - i_tap;
  assign o_rdata = r_hist[w_rdIdx];

endmodule

// File: rtl/fir_mac_ctrl.sv
// Sequences one external multiply-accumulate slice through an NTAPS-tap FIR pass
// per accepted sample and hands the accumulated result out over valid/ready.
module fir_mac_ctrl
  import fir_mac_pkg::*;
#(
  parameter int A_DATA_WIDTH = DEF_A_DATA_WIDTH,
  parameter int B_DATA_WIDTH = DEF_B_DATA_WIDTH,
  parameter int P_DATA_WIDTH = DEF_P_DATA_WIDTH,
  parameter int NTAPS        = DEF_NTAPS
) (
  input logic           clk_i,
  input logic           rst_i,
  fir_mac_ctrl_if.master bus
);

  localparam int                    ADDR_WIDTH = $clog2(NTAPS);
  localparam logic [ADDR_WIDTH-1:0] LAST_TAP   = ADDR_WIDTH'(NTAPS - 1);

  generate
    if (!ntapsValid(NTAPS, A_DATA_WIDTH, B_DATA_WIDTH, P_DATA_WIDTH)) begin : gBadConfig
      $error("fir_mac_ctrl: NTAPS must be a power of two in 2..32 and fit the accumulator");
    end
  endgenerate

  fir_state_e              r_state;
  logic [ADDR_WIDTH-1:0]   r_tap;
  logic [B_DATA_WIDTH-1:0] r_coef [NTAPS];
  logic [P_DATA_WIDTH-1:0] r_mData;
  logic                    r_mValid;
  logic                    r_sReady;
  logic                    r_dspAcc;
  logic [A_DATA_WIDTH-1:0] w_histData;
  logic                    w_accept;

  assign w_accept = (r_state == ST_IDLE) && bus.s_valid_i;

  fir_mac_hist #(
    .A_DATA_WIDTH(A_DATA_WIDTH),
    .NTAPS       (NTAPS)
  ) u_hist (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_we   (w_accept),
    .i_wdata(bus.s_data_i),
    .i_tap  (r_tap),
    .o_rdata(w_histData)
  );

  // Coefficient writes are honoured in every state, so a write mid-pass
  // changes the taps that are read after that edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_coef[i] <= '0;
      end
    end else if (bus.coef_we_i) begin
      r_coef[bus.coef_addr_i] <= bus.coef_data_i;
    end
  end

  // Control sequencer. acc is registered one cycle ahead of the tap it governs:
  // low only for tap 0 so stale slice contents are discarded, high in DRAIN so
  // the slice holds its sum while the result register is blocked.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_tap    <= '0;
      r_mData  <= '0;
      r_mValid <= 1'b0;
      r_sReady <= 1'b1;
      r_dspAcc <= 1'b0;
    end else begin
      if (bus.m_ready_i) begin
        r_mValid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (bus.s_valid_i) begin
            r_state  <= ST_ACCUM;
            r_tap    <= '0;
            r_sReady <= 1'b0;
            r_dspAcc <= 1'b0;
          end
        end
        ST_ACCUM: begin
          r_tap    <= r_tap + 1'b1;
          r_dspAcc <= 1'b1;
          if (r_tap == LAST_TAP) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!r_mValid || bus.m_ready_i) begin
            r_mData  <= bus.dsp_p_i;
            r_mValid <= 1'b1;
            r_state  <= ST_IDLE;
            r_sReady <= 1'b1;
            r_dspAcc <= 1'b0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_sReady <= 1'b1;
          r_dspAcc <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dsp_a_o   = (r_state == ST_ACCUM) ? w_histData    : '0;
  assign bus.dsp_b_o   = (r_state == ST_ACCUM) ? r_coef[r_tap] : '0;
  assign bus.dsp_acc_o = r_dspAcc;
  assign bus.s_ready_o = r_sReady;
  assign bus.m_data_o  = r_mData;
  assign bus.m_valid_o = r_mValid;

  // A blocked result must not change until the consumer takes it.
  assert property (@(posedge clk_i) disable iff (rst_i)
    (r_mValid && !bus.m_ready_i) |=> $stable(r_mData));

endmodule
